cpu_mem_io_responder: RTL and testbench

//  Slave side of the CPU memory/IO bus. Answers CPU loads from the data memory
//  (dmem_out) and performs stores on dmem_we. Queues vmem_we stores into a

---
 rtl/cpu_mem_io_responder_if.sv | 37 +++
 rtl/cpu_mem_io_responder.sv | 174 +++++++++++++++++
 tb/tb_cpu_mem_io_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_io_responder_if.sv
// CPU memory/IO bus bundle: CPU load/store, external input byte stream and
// video write queue head, grouped for the responder and its peers.
// master: CPU + external byte source + video scanner; slave: the responder.
interface cpu_mem_io_responder_if #(
  parameter int ADDR_W = 8
);
  // CPU load/store side
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        b;
  logic              dmem_we;
  logic              vmem_we;
  logic [7:0]        dmem_out;
  // External input byte stream
  logic              ext_valid;
  logic [7:0]        ext_data;
  logic              ext_ready;
  logic [7:0]        gpi;
  logic              gpi_we;
  // Video write queue head
  logic              vid_valid;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_ready;
  logic              vq_overflow;

  modport master (
    output mem_addr, b, dmem_we, vmem_we, ext_valid, ext_data, vid_ready,
    input  dmem_out, ext_ready, gpi, gpi_we, vid_valid, vid_addr, vid_data,
           vq_overflow
  );

  modport slave (
    input  mem_addr, b, dmem_we, vmem_we, ext_valid, ext_data, vid_ready,
    output dmem_out, ext_ready, gpi, gpi_we, vid_valid, vid_addr, vid_data,
           vq_overflow
  );
endinterface

// File: rtl/cpu_mem_io_responder.sv
// Slave side of the CPU memory/IO bus: data memory, video write queue, GPI feed.
// Latency: loads 1 cycle; queue push visible next cycle; byte accept -> gpi_we next cycle.
// Backpressure: ext_ready only in IDLE; full video queue drops stores (sticky vq_overflow).
// Ports: clock, reset (sync, active-low) and bus (cpu_mem_io_responder_if.slave).
// Optional MMIO_STATUS_EN: the all-ones address reads a status byte and a store
// there clears vq_overflow instead of writing memory.
module cpu_mem_io_responder #(
  parameter int ADDR_W     = 8,
  parameter int DMEM_DEPTH = 256,
  parameter int VQ_DEPTH   = 4,
  parameter int GPI_GAP    = 4
) (
  input logic                     clock,
  input logic                     reset,
  cpu_mem_io_responder_if.slave   bus
);

  localparam int IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int PTR_W = $clog2(VQ_DEPTH);
  localparam int CNT_W = $clog2(GPI_GAP + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } vq_entry_t;

  // ---------------- data memory ----------------
  logic [7:0]       mem [DMEM_DEPTH];
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             mem_wr;
  logic [7:0]       rd_dat;
  logic [7:0]       dmem_out_q;

  // ---------------- video queue ----------------
  vq_entry_t        vq [VQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   vq_count;
  logic             vq_full, vq_vld, pop, push_ok, push_drop;
  logic             ovf_q;

  // ---------------- GPI FSM ----------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       gpi_q, gpi_nxt;
  logic             ext_ready_c, gpi_we_c;

`ifdef MMIO_STATUS_EN
  logic       mmio_hit;
  logic [7:0] status;
  assign mmio_hit = &bus.mem_addr;
  assign status   = {ovf_q, vq_vld, vq_full, 2'b00, 1'b0, state};
`endif

  assign mem_idx  = bus.mem_addr[IDX_W-1:0];
  assign in_range = {1'b0, bus.mem_addr} < (ADDR_W+1)'(DMEM_DEPTH);
`ifdef MMIO_STATUS_EN
  assign mem_wr   = bus.dmem_we & in_range & ~mmio_hit;
`else
  assign mem_wr   = bus.dmem_we & in_range;
`endif

  // Memory array is deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_wr) mem[mem_idx] <= bus.b;
  end

  // Write-first: a store to the addressed cell returns the store data.
  always_comb begin
    rd_dat = 8'hff;
    if (in_range) rd_dat = bus.dmem_we ? bus.b : mem[mem_idx];
`ifdef MMIO_STATUS_EN
    if (mmio_hit) rd_dat = status;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) dmem_out_q <= 8'hff;
    else        dmem_out_q <= rd_dat;
  end

  // Video queue: a pop frees a slot in the same cycle, so push into a full
  // queue succeeds when the head is consumed at the same edge.
  assign vq_vld    = (vq_count != '0);
  assign vq_full   = (vq_count == (PTR_W+1)'(VQ_DEPTH));
  assign pop       = vq_vld & bus.vid_ready;
  assign push_ok   = bus.vmem_we & (~vq_full | pop);
  assign push_drop = bus.vmem_we & vq_full & ~pop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      vq_count <= '0;
      for (int i = 0; i < VQ_DEPTH; i++) vq[i] <= '0;
    end else begin
      if (push_ok) begin
        vq[wr_ptr] <= '{addr: bus.mem_addr, data: bus.b};
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   vq_count <= vq_count + 1'b1;
        2'b01:   vq_count <= vq_count - 1'b1;
        default: vq_count <= vq_count;
      endcase
    end
  end

  // A drop in the same cycle as a clearing store leaves the flag set.
  always_ff @(posedge clock) begin
    if (!reset)                         ovf_q <= 1'b0;
    else if (push_drop)                 ovf_q <= 1'b1;
`ifdef MMIO_STATUS_EN
    else if (mmio_hit && bus.dmem_we)   ovf_q <= 1'b0;
`endif
  end

  // GPI FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      gpi_q <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gpi_q <= gpi_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gpi_nxt     = gpi_q;
    ext_ready_c = 1'b0;
    gpi_we_c    = 1'b0;
    case (state)
      IDLE: begin
        ext_ready_c = 1'b1;
        if (bus.ext_valid) begin
          gpi_nxt   = bus.ext_data;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        gpi_we_c = 1'b1;
        if (GPI_GAP == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(GPI_GAP);
        end
      end
      GAP: begin
        if (cnt <= CNT_W'(1)) state_nxt = IDLE;
        else                  cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dmem_out    = dmem_out_q;
  assign bus.ext_ready   = ext_ready_c;
  assign bus.gpi         = gpi_q;
  assign bus.gpi_we      = gpi_we_c;
  assign bus.vid_valid   = vq_vld;
  assign bus.vid_addr    = vq[rd_ptr].addr;
  assign bus.vid_data    = vq[rd_ptr].data;
  assign bus.vq_overflow = ovf_q;

endmodule

// File: tb/tb_cpu_mem_io_responder.sv
// Directed self-checking bench for cpu_mem_io_responder.
// Instance uses DMEM_DEPTH=128 so that out-of-range addresses are exercised.
// Stimulus changes 1 time unit after the rising edge; outputs are sampled there too.
module tb_cpu_mem_io_responder;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_mem_io_responder_if #(.ADDR_W(8)) bus ();

  cpu_mem_io_responder #(
    .ADDR_W(8), .DMEM_DEPTH(128), .VQ_DEPTH(4), .GPI_GAP(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++; if (bus.dmem_out !== 8'hff) begin n_fail++; $display("FAIL reset_dmem_out got %h expected ff", bus.dmem_out); end
    n_checks++; if (bus.gpi_we !== 1'b0) begin n_fail++; $display("FAIL reset_gpi_we got %b expected 0", bus.gpi_we); end
    n_checks++; if (bus.gpi !== 8'h00) begin n_fail++; $display("FAIL reset_gpi got %h expected 00", bus.gpi); end
    n_checks++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vid_valid got %b expected 0", bus.vid_valid); end
    n_checks++; if (bus.ext_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ext_ready got %b expected 1", bus.ext_ready); end
    n_checks++; if (bus.vq_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_vq_overflow got %b expected 0", bus.vq_overflow); end
  endtask

  task automatic test_dmem();
    bus.mem_addr = 8'h10; bus.b = 8'h5a; bus.dmem_we = 1'b1; tick();
    bus.mem_addr = 8'h11; bus.b = 8'h77; tick();
    n_checks++; if (bus.dmem_out !== 8'h77) begin n_fail++; $display("FAIL dmem_store_11 got %h expected 77", bus.dmem_out); end
    bus.dmem_we = 1'b0; bus.mem_addr = 8'h10; tick();
    n_checks++; if (bus.dmem_out !== 8'h5a) begin n_fail++; $display("FAIL dmem_load_10 got %h expected 5a", bus.dmem_out); end
    bus.mem_addr = 8'h11; tick();
    n_checks++; if (bus.dmem_out !== 8'h77) begin n_fail++; $display("FAIL dmem_load_11 got %h expected 77", bus.dmem_out); end
    // write-first: old C3, same-cycle store 3C must be returned
    bus.mem_addr = 8'h20; bus.b = 8'hc3; bus.dmem_we = 1'b1; tick();
    bus.b = 8'h3c; tick();
    n_checks++; if (bus.dmem_out !== 8'h3c) begin n_fail++; $display("FAIL dmem_write_first got %h expected 3c", bus.dmem_out); end
    bus.dmem_we = 1'b0; tick();
    n_checks++; if (bus.dmem_out !== 8'h3c) begin n_fail++; $display("FAIL dmem_reload_20 got %h expected 3c", bus.dmem_out); end
    // 0x90 is beyond depth 128 and aliases 0x10 if truncated
    bus.mem_addr = 8'h90; bus.b = 8'h12; bus.dmem_we = 1'b1; tick();
    n_checks++; if (bus.dmem_out !== 8'hff) begin n_fail++; $display("FAIL dmem_out_of_range got %h expected ff", bus.dmem_out); end
    bus.dmem_we = 1'b0; bus.mem_addr = 8'h10; tick();
    n_checks++; if (bus.dmem_out !== 8'h5a) begin n_fail++; $display("FAIL dmem_no_alias got %h expected 5a", bus.dmem_out); end
  endtask

  task automatic test_gpi();
    int cyc;
    bus.ext_valid = 1'b1; bus.ext_data = 8'ha7; tick();
    n_checks++; if (bus.gpi !== 8'ha7) begin n_fail++; $display("FAIL gpi_first got %h expected a7", bus.gpi); end
    n_checks++; if (bus.gpi_we !== 1'b1) begin n_fail++; $display("FAIL gpi_we_first got %b expected 1", bus.gpi_we); end
    n_checks++; if (bus.ext_ready !== 1'b0) begin n_fail++; $display("FAIL gpi_ready_strobe got %b expected 0", bus.ext_ready); end
    bus.ext_data = 8'hb8; tick();
    n_checks++; if (bus.gpi_we !== 1'b0) begin n_fail++; $display("FAIL gpi_we_one_cycle got %b expected 0", bus.gpi_we); end
    n_checks++; if (bus.gpi !== 8'ha7) begin n_fail++; $display("FAIL gpi_hold got %h expected a7", bus.gpi); end
    cyc = 1;
    while (bus.gpi_we !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL gpi_rate got %0d cycles expected 6", cyc); end
    n_checks++; if (bus.gpi !== 8'hb8) begin n_fail++; $display("FAIL gpi_second got %h expected b8", bus.gpi); end
    bus.ext_valid = 1'b0;
    repeat (6) tick();
    n_checks++; if (bus.ext_ready !== 1'b1) begin n_fail++; $display("FAIL gpi_back_idle got %b expected 1", bus.ext_ready); end
  endtask

  task automatic test_vq_overflow();
    bus.vid_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_addr = 8'(i); bus.b = 8'(8'h40 + i); bus.vmem_we = 1'b1;
      bus.dmem_we = (i == 4);
      tick();
      if (i == 0) begin
        n_checks++; if (bus.vid_valid !== 1'b1) begin n_fail++; $display("FAIL vq_valid_after_push got %b expected 1", bus.vid_valid); end
      end
    end
    bus.vmem_we = 1'b0; bus.dmem_we = 1'b0;
    n_checks++; if (bus.vq_overflow !== 1'b1) begin n_fail++; $display("FAIL vq_overflow_set got %b expected 1", bus.vq_overflow); end
    n_checks++; if (bus.vid_addr !== 8'h00 || bus.vid_data !== 8'h40) begin n_fail++; $display("FAIL vq_head_stable got %h/%h expected 00/40", bus.vid_addr, bus.vid_data); end
    bus.vid_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.vid_valid !== 1'b1 || bus.vid_addr !== 8'(i) || bus.vid_data !== 8'(8'h40 + i)) begin
        n_fail++; $display("FAIL vq_pop_%0d got v=%b %h/%h expected v=1 %h/%h", i, bus.vid_valid, bus.vid_addr, bus.vid_data, 8'(i), 8'(8'h40 + i));
      end
      tick();
    end
    n_checks++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL vq_drained got %b expected 0", bus.vid_valid); end
    bus.vid_ready = 1'b0;
    bus.mem_addr = 8'h04; tick();
    n_checks++; if (bus.dmem_out !== 8'h44) begin n_fail++; $display("FAIL vq_dual_store got %h expected 44", bus.dmem_out); end
  endtask

  task automatic test_mmio();
    bus.mem_addr = 8'hff; bus.dmem_we = 1'b0; tick();
`ifdef MMIO_STATUS_EN
    n_checks++; if (bus.dmem_out !== 8'h80) begin n_fail++; $display("FAIL mmio_status got %h expected 80", bus.dmem_out); end
    bus.dmem_we = 1'b1; bus.b = 8'h00; tick();
    bus.dmem_we = 1'b0;
    n_checks++; if (bus.vq_overflow !== 1'b0) begin n_fail++; $display("FAIL mmio_clear got %b expected 0", bus.vq_overflow); end
    tick();
    n_checks++; if (bus.dmem_out !== 8'h00) begin n_fail++; $display("FAIL mmio_status_after got %h expected 00", bus.dmem_out); end
`else
    n_checks++; if (bus.dmem_out !== 8'hff) begin n_fail++; $display("FAIL top_addr_load got %h expected ff", bus.dmem_out); end
    n_checks++; if (bus.vq_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %b expected 1", bus.vq_overflow); end
`endif
  endtask

  task automatic test_full_push_pop();
    reset = 1'b0; tick(); reset = 1'b1;
    n_checks++; if (bus.vq_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_reset_ovf got %b expected 0", bus.vq_overflow); end
    bus.vid_ready = 1'b0;
    for (int i = 8; i < 12; i++) begin
      bus.mem_addr = 8'(i); bus.b = 8'(8'h80 + i); bus.vmem_we = 1'b1; tick();
    end
    bus.mem_addr = 8'h0c; bus.b = 8'h8c; bus.vid_ready = 1'b1; tick();
    bus.vmem_we = 1'b0;
    n_checks++; if (bus.vq_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_overflow got %b expected 0", bus.vq_overflow); end
    for (int i = 9; i < 13; i++) begin
      n_checks++;
      if (bus.vid_valid !== 1'b1 || bus.vid_addr !== 8'(i)) begin
        n_fail++; $display("FAIL fpp_pop_%0d got v=%b addr=%h expected v=1 addr=%h", i, bus.vid_valid, bus.vid_addr, 8'(i));
      end
      tick();
    end
    n_checks++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained got %b expected 0", bus.vid_valid); end
    bus.vid_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.ext_valid = 1'b1; bus.ext_data = 8'h5c;
    bus.mem_addr = 8'h03; bus.b = 8'h33; bus.vmem_we = 1'b1; tick();
    bus.ext_valid = 1'b0; bus.vmem_we = 1'b0;
    n_checks++; if (bus.gpi_we !== 1'b1 || bus.vid_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got we=%b v=%b expected 1/1", bus.gpi_we, bus.vid_valid); end
    reset = 1'b0; tick();
    n_checks++; if (bus.gpi_we !== 1'b0 || bus.gpi !== 8'h00) begin n_fail++; $display("FAIL mid_gpi got we=%b gpi=%h expected 0/00", bus.gpi_we, bus.gpi); end
    n_checks++; if (bus.vid_valid !== 1'b0 || bus.dmem_out !== 8'hff) begin n_fail++; $display("FAIL mid_vq got v=%b dout=%h expected 0/ff", bus.vid_valid, bus.dmem_out); end
    reset = 1'b1; tick();
    n_checks++; if (bus.ext_ready !== 1'b1 || bus.gpi_we !== 1'b0) begin n_fail++; $display("FAIL mid_idle got rdy=%b we=%b expected 1/0", bus.ext_ready, bus.gpi_we); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.mem_addr  = '0;
    bus.b         = '0;
    bus.dmem_we   = 1'b0;
    bus.vmem_we   = 1'b0;
    bus.ext_valid = 1'b0;
    bus.ext_data  = '0;
    bus.vid_ready = 1'b0;
    #1;
    test_reset();
    test_dmem();
    test_gpi();
    test_vq_overflow();
    test_mmio();
    test_full_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
